// File: rtl/ecp5pll_phase_ctrl.sv
// Sequences one phase-shift request onto the ecp5pll dynamic phase port.
// Define ECP5PLL_PHASECTRL_LOCKWAIT_EN to gate each request on PLL lock and abort on lock loss.
module ecp5pll_phase_ctrl #(
    parameter int unsigned SETUP_CYC = 2,
    parameter int unsigned STEP_HIGH = 4,
    parameter int unsigned STEP_GAP  = 4,
    parameter int unsigned COUNT_W   = 8
) (
    input  logic               clk_i,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [1:0]         req_sel,
    input  logic               req_dir,
    input  logic [COUNT_W-1:0] req_steps,
    input  logic               locked,
    output logic [1:0]         phasesel,
    output logic               phasedir,
    output logic               phasestep,
    output logic               phaseloadreg,
    output logic               busy,
    output logic               done,
    output logic               abort,
    output logic [COUNT_W-1:0] steps_done
);

    localparam int unsigned CYC_MAX0 = (SETUP_CYC > STEP_HIGH) ? SETUP_CYC : STEP_HIGH;
    localparam int unsigned CYC_MAX  = (CYC_MAX0 > STEP_GAP) ? CYC_MAX0 : STEP_GAP;
    localparam int unsigned CYC_W    = $clog2(CYC_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STEP_HI,
        S_STEP_LO,
        S_DONE
`ifdef ECP5PLL_PHASECTRL_LOCKWAIT_EN
        ,
        S_WAIT_LOCK,
        S_ABORT
`endif
    } state_e;

    state_e             state_q, state_d;
    logic [CYC_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         sel_q, sel_d;
    logic               dir_q, dir_d;
    logic [COUNT_W-1:0] rem_q, rem_d;
    logic [COUNT_W-1:0] steps_done_q, steps_done_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               step_q, step_d;
    logic               done_q, done_d;

`ifdef ECP5PLL_PHASECTRL_LOCKWAIT_EN
    logic [1:0] sync_q;
    logic       lock_s;
    logic       pend_q, pend_d;
    logic       abort_q, abort_d;

    // Two-flop synchroniser for the asynchronous lock indicator
    always_ff @(posedge clk_i) begin
        if (reset) begin
            sync_q  <= 2'b00;
            pend_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], locked};
            pend_q  <= pend_d;
            abort_q <= abort_d;
        end
    end

    assign lock_s = sync_q[1];
    assign abort  = abort_q;
`else
    logic unused_locked;
    assign unused_locked = locked;
    assign abort         = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + CYC_W'(1);
        sel_d        = sel_q;
        dir_d        = dir_q;
        rem_d        = rem_q;
        steps_done_d = steps_done_q;
`ifdef ECP5PLL_PHASECTRL_LOCKWAIT_EN
        pend_d       = pend_q;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (req_valid && ready_q) begin
                    sel_d        = req_sel;
                    dir_d        = req_dir;
                    rem_d        = req_steps;
                    steps_done_d = '0;
`ifdef ECP5PLL_PHASECTRL_LOCKWAIT_EN
                    pend_d       = 1'b0;
                    // Skip the wait entirely when lock is already present
                    state_d      = lock_s ? S_SETUP : S_WAIT_LOCK;
`else
                    state_d      = S_SETUP;
`endif
                end
            end
`ifdef ECP5PLL_PHASECTRL_LOCKWAIT_EN
            S_WAIT_LOCK: begin
                cnt_d = '0;
                if (lock_s) state_d = S_SETUP;
            end
            S_ABORT: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
`endif
            S_SETUP: begin
                if (cnt_q == CYC_W'(SETUP_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = (rem_q == '0) ? S_DONE : S_STEP_HI;
                end
            end
            S_STEP_HI: begin
                if (cnt_q == CYC_W'(STEP_HIGH - 1)) begin
                    cnt_d        = '0;
                    steps_done_d = steps_done_q + COUNT_W'(1);
                    rem_d        = rem_q - COUNT_W'(1);
                    state_d      = S_STEP_LO;
                end
            end
            S_STEP_LO: begin
                if (cnt_q == CYC_W'(STEP_GAP - 1)) begin
                    cnt_d = '0;
                    if (rem_q == '0) state_d = S_DONE;
`ifdef ECP5PLL_PHASECTRL_LOCKWAIT_EN
                    else if (pend_q) state_d = S_ABORT;
`endif
                    else state_d = S_STEP_HI;
                end
            end
            S_DONE: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase

`ifdef ECP5PLL_PHASECTRL_LOCKWAIT_EN
        // Lock loss during a pulse is remembered and acted on after the gap
        if ((state_q == S_STEP_HI || state_q == S_STEP_LO) && !lock_s) pend_d = 1'b1;
        abort_d = (state_d == S_ABORT);
`endif
        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
        step_d  = (state_d == S_STEP_HI);
        done_d  = (state_d == S_DONE);
    end

    always_ff @(posedge clk_i) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            sel_q        <= 2'b00;
            dir_q        <= 1'b0;
            rem_q        <= '0;
            steps_done_q <= '0;
            ready_q      <= 1'b0;
            busy_q       <= 1'b0;
            step_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sel_q        <= sel_d;
            dir_q        <= dir_d;
            rem_q        <= rem_d;
            steps_done_q <= steps_done_d;
            ready_q      <= ready_d;
            busy_q       <= busy_d;
            step_q       <= step_d;
            done_q       <= done_d;
        end
    end

    assign req_ready    = ready_q;
    assign phasesel     = sel_q;
    assign phasedir     = dir_q;
    assign phasestep    = step_q;
    assign phaseloadreg = 1'b0;
    assign busy         = busy_q;
    assign done         = done_q;
    assign steps_done   = steps_done_q;

endmodule

// File: doc/ecp5pll_phase_ctrl.md
# ecp5pll_phase_ctrl

Sequencer for the dynamic phase-adjust port of the `ecp5pll` wrapper, instantiated with `dynamic_en=1`. It accepts one phase-shift request at a time: an output select, a direction and a step count. It then drives `phasesel`/`phasedir`/`phasestep`/`phaseloadreg` with the setup and pulse timing the EHXPLLL requires. Each step moves the selected output by 1/8 VCO period. It sits between a register interface (or an auto-calibration FSM, e.g. SDRAM/DVI clock alignment) and `ecp5pll`.

## Interface
Parameters:
- `SETUP_CYC`, 2: cycles `phasesel`/`phasedir` are held stable before the first `phasestep` rise; must be ≥1.
- `STEP_HIGH`, 4: cycles `phasestep` stays high per step; must be ≥1.
- `STEP_GAP`, 4: cycles `phasestep` stays low after each high phase, including the last; must be ≥1.
- `COUNT_W`, 8: width of the step count.

Ports:
- `clk_i` in 1: the single clock. It must not be a PLL output whose phase is being shifted.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller can accept a request.
- `req_sel` in 2: output index; 0=CLKOP, 1=CLKOS, 2=CLKOS2, 3=CLKOS3. This is the same numbering as the `ecp5pll` `phasesel` input.
- `req_dir` in 1: 0 = delay (lag), 1 = advance (lead). Passed straight through to `phasedir`.
- `req_steps` in COUNT_W: number of 45°-VCO steps; 0 is legal.
- `locked` in 1: PLL lock, asynchronous to `clk_i`, synchronised internally.
- `phasesel` out 2: to `ecp5pll`.
- `phasedir` out 1: to `ecp5pll`.
- `phasestep` out 1: to `ecp5pll`.
- `phaseloadreg` out 1: to `ecp5pll`; constant 0.
- `busy` out 1: a request is in progress.
- `done` out 1: one-cycle pulse on normal completion.
- `abort` out 1: one-cycle pulse on completion due to lock loss.
- `steps_done` out COUNT_W: number of pulses issued for the current/last request.

## Operation
- All outputs are registered.
- Reset values: `req_ready=0`, `phasesel=0`, `phasedir=0`, `phasestep=0`, `phaseloadreg=0`, `busy=0`, `done=0`, `abort=0`, `steps_done=0`, state IDLE.
- In the cycle after reset deasserts, state is IDLE and `req_ready=1`.
- Lock synchroniser: two flops on `locked`, producing `lock_s`. Reset clears both flops.
- States and transitions:
  - IDLE: `req_ready=1`. On `req_valid&&req_ready`:
    - latch sel, dir and steps;
    - clear `steps_done`;
    - drive `phasesel`/`phasedir`;
    - go to WAIT_LOCK if `ECP5PLL_PHASECTRL_LOCKWAIT_EN` is defined, else go to SETUP.
  - WAIT_LOCK: stay until `lock_s=1`, then go to SETUP.
  - SETUP: count `SETUP_CYC` cycles. Then:
    - if remaining steps = 0, go to DONE;
    - otherwise go to STEP_HI.
  - STEP_HI: `phasestep=1` for `STEP_HIGH` cycles. On exit, increment `steps_done` and decrement the remaining count, then go to STEP_LO.
  - STEP_LO: `phasestep=0` for `STEP_GAP` cycles. Then:
    - if remaining = 0, go to DONE;
    - if an abort is pending, go to ABORT;
    - otherwise go to STEP_HI.
  - DONE: `done=1` for one cycle, then IDLE.
  - ABORT: `abort=1` for one cycle, then IDLE.
- `busy=1` in every state except IDLE.
- `phasesel` and `phasedir` are held constant from acceptance until the return to IDLE. They keep their last value while IDLE.
- `steps_done` is held in IDLE until the next acceptance.
- Counters are unsigned COUNT_W. The remaining count never underflows; a zero count is tested before every STEP_HI.
- Reset mid-operation returns to the reset state immediately, even if `phasestep` is high. A truncated pulse may or may not register in the PLL; software must recalibrate after reset.
- `req_valid` while busy is ignored and never queued.

## Timing
- Acceptance occurs at clock edge E0, when `req_valid&&req_ready` is sampled.
  - `phasesel`/`phasedir` are valid from E0.
  - `req_ready` is low from E0.
- Without LOCKWAIT, for N≥1:
  - `phasestep` rises at E0+SETUP_CYC;
  - pulse k (0-based) is high over [E0+SETUP_CYC+k·(H+G), +H), where H=STEP_HIGH and G=STEP_GAP;
  - `done` is high for the cycle starting at E0+SETUP_CYC+N·(H+G);
  - `req_ready` returns at that edge +1.
- For N=0, `done` is at E0+SETUP_CYC and no pulse is issued.
- With LOCKWAIT, every time above shifts by the number of cycles spent in WAIT_LOCK. This is 0 if `lock_s` is already 1 at E0.

## Configuration
- `ECP5PLL_PHASECTRL_LOCKWAIT_EN` defined:
  - WAIT_LOCK is used.
  - While in STEP_HI or STEP_LO, `lock_s=0` sets an abort-pending flag. The current pulse completes its full high and gap periods, then the state goes to ABORT and `abort` pulses.
  - Abort has priority over remaining steps, but not over remaining=0: if the last gap ends, DONE is taken.
- Not defined:
  - `locked` is ignored, the synchroniser may be removed, and `abort` is tied to 0.
  - The WAIT_LOCK and ABORT states do not exist.

## Test plan
- Reset deasserted, sel=1, dir=1, steps=3, defaults, `locked`=1: `phasestep` rises 2 cycles after acceptance, 3 pulses each 4 high/4 low, `phasesel`=1 and `phasedir`=1 throughout, `done` at E0+26, `steps_done`=3.
- steps=0, sel=3: no `phasestep` activity, `done` at E0+2, `steps_done`=0.
- Second `req_valid` held high while busy: ignored. The following request is accepted exactly one cycle after `done`.
- LOCKWAIT_EN, `locked`=0 at acceptance, raised 10 cycles later: first `phasestep` rise is delayed accordingly (synchroniser latency plus SETUP_CYC after the raise).
- LOCKWAIT_EN, steps=5, `locked` dropped during the 2nd high phase: that pulse completes 4 high/4 low, `abort` pulses, `steps_done`=2, no 3rd pulse.
- `reset` asserted during STEP_HI: next cycle `phasestep`=0, `busy`=0, `steps_done`=0; `req_ready`=1 one cycle after reset release.
